// File: rtl/rbm_layer_pipe.sv
// rtl/rbm_layer_pipe.sv - RBM hidden-layer evaluator: lane-parallel accumulate, saturate, threshold/stochastic sample
module rbm_layer_pipe #(
  parameter int          IN_DIM  = 16,
  parameter int          OUT_DIM = 8,
  parameter int          LANES   = 4,
  parameter int          ACC_W   = 16,
  parameter int          W_W     = 12,
  parameter int          SIG_W   = 8,
  parameter logic [15:0] SEED    = 16'hACE1,
  localparam int         DEPTH   = IN_DIM * OUT_DIM + OUT_DIM,
  localparam int         AW      = $clog2(DEPTH)
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               start,
  input  logic               det_mode,
  input  logic [IN_DIM-1:0]  in_data,
  input  logic               w_we,
  input  logic [AW-1:0]      w_addr,
  input  logic [W_W-1:0]     w_data,
  output logic               w_err,
  output logic               busy,
  output logic               done,
  output logic [OUT_DIM-1:0] out_data
);

  localparam int K      = (IN_DIM + LANES - 1) / LANES;
  localparam int KW     = $clog2(K * LANES + 1);
  localparam int JW     = (OUT_DIM > 1) ? $clog2(OUT_DIM) : 1;
  localparam int IW     = (IN_DIM > 1) ? $clog2(IN_DIM) : 1;
  localparam int SUM_W  = W_W + $clog2(LANES + 1);
  localparam int FW     = ((ACC_W > SUM_W) ? ACC_W : SUM_W) + 2;
  localparam int BIAS_BASE = IN_DIM * OUT_DIM;

  // Symmetric saturation limits keep -(2^(ACC_W-1)) out so negation never overflows.
  localparam longint              SAT_HI_L = (64'sd1 <<< (ACC_W - 1)) - 64'sd1;
  localparam logic signed [FW-1:0] SAT_HI  = FW'(SAT_HI_L);
  localparam logic signed [FW-1:0] SAT_LO  = -SAT_HI;

  // Hard sigmoid: slope 1/4 around the mid-code, clamped to the SIG_W range.
  localparam int                      SIG_SHIFT = 2;
  localparam logic signed [ACC_W:0]   SIG_MID   = (ACC_W + 1)'(1 << (SIG_W - 1));
  localparam logic signed [ACC_W:0]   SIG_MAX   = (ACC_W + 1)'((1 << SIG_W) - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_BIAS,
    S_ACCUM,
    S_SAMPLE,
    S_DONE
  } state_t;

  state_t                   r_state;
  logic                     r_busy;
  logic                     r_done;
  logic                     r_w_err;
  logic [OUT_DIM-1:0]       r_out;
  logic signed [ACC_W-1:0]  r_acc;
  logic [JW-1:0]            r_j;
  logic [KW-1:0]            r_k;
  logic [15:0]              r_lfsr;
  logic [IN_DIM-1:0]        r_in;
  logic                     r_det;

  logic signed [W_W-1:0]    r_mem [DEPTH];

  logic                     w_addr_ok;
  logic                     w_wr_ok;
  logic signed [FW-1:0]     w_lane_sum;
  logic signed [FW-1:0]     w_acc_full;
  logic signed [ACC_W-1:0]  w_acc_sat;
  logic signed [ACC_W-1:0]  w_bias_ext;
  logic signed [ACC_W:0]    w_sig_lin;
  logic [SIG_W-1:0]         w_sig;
  logic                     w_k_last;
  logic                     w_j_last;
  logic                     w_sample_bit;
  logic [15:0]              w_lfsr_next;

  assign w_addr_ok = ({1'b0, w_addr} < (AW + 1)'(DEPTH));
  assign w_wr_ok   = w_we && (r_state == S_IDLE) && w_addr_ok;

  // Weight/bias storage has no reset; only IDLE-state in-range writes land.
  always_ff @(posedge clock) begin
    if (w_wr_ok) begin
      r_mem[w_addr] <= w_data;
    end
  end

  // Gated sum of this cycle's lanes; lanes past the last visible input add nothing.
  always_comb begin : lane_sum
    int v_idx;
    w_lane_sum = '0;
    v_idx      = 0;
    for (int l = 0; l < LANES; l++) begin
      v_idx = int'(r_k) + l;
      if (v_idx < IN_DIM) begin
        if (r_in[IW'(v_idx)]) begin
          w_lane_sum = w_lane_sum + FW'(r_mem[AW'(v_idx * OUT_DIM + int'(r_j))]);
        end
      end
    end
  end

  // Full-precision accumulate followed by symmetric saturation back to ACC_W.
  always_comb begin
    w_acc_full = FW'(r_acc) + w_lane_sum;
    if (w_acc_full > SAT_HI) begin
      w_acc_sat = ACC_W'(SAT_HI);
    end else if (w_acc_full < SAT_LO) begin
      w_acc_sat = ACC_W'(SAT_LO);
    end else begin
      w_acc_sat = ACC_W'(w_acc_full);
    end
  end

  assign w_bias_ext = ACC_W'(r_mem[AW'(BIAS_BASE + int'(r_j))]);

  // Sigmoid of the current accumulator as an unsigned SIG_W probability code.
  always_comb begin
    w_sig_lin = (ACC_W + 1)'(r_acc >>> SIG_SHIFT) + SIG_MID;
    if (w_sig_lin < 0) begin
      w_sig = '0;
    end else if (w_sig_lin > SIG_MAX) begin
      w_sig = SIG_W'(SIG_MAX);
    end else begin
      w_sig = SIG_W'(w_sig_lin);
    end
  end

  assign w_k_last     = (int'(r_k) + LANES >= IN_DIM);
  assign w_j_last     = (r_j == JW'(OUT_DIM - 1));
  assign w_sample_bit = r_det ? (r_acc > 0) : (w_sig > r_lfsr[SIG_W-1:0]);
  assign w_lfsr_next  = {r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5], r_lfsr[15:1]};

  // Control FSM with registered busy/done/w_err/out_data and datapath registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_w_err <= 1'b0;
      r_out   <= '0;
      r_acc   <= '0;
      r_j     <= '0;
      r_k     <= '0;
      r_lfsr  <= SEED;
      r_in    <= '0;
      r_det   <= 1'b0;
    end else begin
      r_w_err <= w_we && !((r_state == S_IDLE) && w_addr_ok);
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_in    <= in_data;
            r_det   <= det_mode;
            r_j     <= '0;
            r_busy  <= 1'b1;
            r_state <= S_BIAS;
          end
        end
        S_BIAS: begin
          r_acc   <= w_bias_ext;
          r_k     <= '0;
          r_state <= S_ACCUM;
        end
        S_ACCUM: begin
          r_acc <= w_acc_sat;
          r_k   <= r_k + KW'(LANES);
          if (w_k_last) begin
            r_state <= S_SAMPLE;
          end
        end
        S_SAMPLE: begin
          r_out[r_j] <= w_sample_bit;
          r_lfsr     <= w_lfsr_next;
          if (w_j_last) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_j     <= r_j + 1'b1;
            r_state <= S_BIAS;
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign w_err    = r_w_err;
  assign busy     = r_busy;
  assign done     = r_done;
  assign out_data = r_out;

endmodule

// File: doc/rbm_layer_pipe.md
RBM_LAYER_PIPE -- requirements
Module: rbm_layer_pipe

Interface
REQ-001 SHALL have parameter IN_DIM, default 16, number of visible inputs.
REQ-002 SHALL have parameter OUT_DIM, default 8, number of output units.
REQ-003 SHALL have parameter LANES, default 4, weights summed per accumulate cycle; range 1..IN_DIM.
REQ-004 SHALL have parameter ACC_W, default 16, signed accumulator width.
REQ-005 SHALL have parameter W_W, default 12, signed weight/bias width; W_W <= ACC_W.
REQ-006 SHALL have parameter SIG_W, default 8, sigmoid and random comparison width.
REQ-007 SHALL have parameter SEED, default 16'hACE1, nonzero LFSR seed.
REQ-008 SHALL have port clock, input, 1, the only clock.
REQ-009 SHALL have port reset_n, input, 1; reset is asynchronous and active-low.
REQ-010 SHALL have port start, input, 1, single-cycle request to evaluate the layer.
REQ-011 SHALL have port det_mode, input, 1; 1 = threshold sampling, 0 = stochastic sampling; latched at start.
REQ-012 SHALL have port in_data, input, IN_DIM, binary visible vector; latched at start.
REQ-013 SHALL have ports w_we (input, 1), w_addr (input, clog2(IN_DIM*OUT_DIM+OUT_DIM)), w_data (input, W_W): weight/bias write port.
REQ-014 SHALL have port w_err, output, 1, pulses when a write is dropped.
REQ-015 SHALL have port busy, output, 1, high from accepted start until done.
REQ-016 SHALL have port done, output, 1, one-cycle completion pulse.
REQ-017 SHALL have port out_data, output, OUT_DIM, sampled hidden vector.

Function
REQ-018 Address map SHALL be: addr i*OUT_DIM+j -> weight W[i][j]; addr IN_DIM*OUT_DIM+j -> bias B[j]; out-of-range writes dropped with w_err.
REQ-019 Writes SHALL take effect only in IDLE; w_we while busy SHALL be dropped and w_err pulse the next cycle.
REQ-020 FSM states SHALL be IDLE, BIAS, ACCUM, SAMPLE, DONE.
REQ-021 IDLE: start=1 SHALL latch in_data and det_mode, set j=0, go BIAS; start in any other state SHALL be ignored.
REQ-022 BIAS: acc SHALL load sign-extended B[j]; lane cursor k=0; go ACCUM.
REQ-023 ACCUM: each cycle acc SHALL add sum over lanes l of W[k+l][j] gated by in_data[k+l]; lanes with k+l >= IN_DIM contribute 0; k += LANES.
REQ-024 ACCUM SHALL last exactly K = ceil(IN_DIM/LANES) cycles, then go SAMPLE.
REQ-025 Lane sum and accumulation SHALL be computed at full precision then saturated to [-(2^(ACC_W-1)-1), 2^(ACC_W-1)-1]; no wrap-around.
REQ-026 SAMPLE: det_mode=1 -> out_data[j] = (acc > 0); det_mode=0 -> out_data[j] = (sigmoid(acc) > lfsr[SIG_W-1:0]), sigmoid being the existing sigmoid block.
REQ-027 LFSR SHALL be 16-bit maximal-length (x^16+x^14+x^13+x^11+1), advancing once per SAMPLE cycle only.
REQ-028 After SAMPLE, j<OUT_DIM-1 SHALL go BIAS with j+1; j=OUT_DIM-1 SHALL go DONE.
REQ-029 DONE: done=1 for exactly one cycle, busy deasserts same cycle, return IDLE.
REQ-030 Latency start->done SHALL be OUT_DIM*(K+2)+1 cycles.
REQ-031 out_data bits SHALL update only in their SAMPLE cycle; bits hold last value between runs.
REQ-032 start coincident with done-cycle SHALL be ignored; start accepted from the following IDLE cycle.

Reset
REQ-033 reset_n low SHALL asynchronously force IDLE, busy=0, done=0, w_err=0, out_data=0, acc=0, j=0, k=0, lfsr=SEED.
REQ-034 Weight/bias storage SHALL NOT be cleared by reset; contents are undefined until written.
REQ-035 Reset mid-run SHALL abort the run with no done pulse; a new start after reset_n high SHALL run a full evaluation.

Verification
REQ-036 Defaults, det_mode=1, all W=1, B=-8, in_data=16'h00FF -> acc=0 each unit, out_data=8'h00, done at cycle 8*(4+2)+1=49.
REQ-037 Same, in_data=16'h01FF -> acc=+1, out_data=8'hFF; busy high 48 cycles.
REQ-038 IN_DIM=10, LANES=4, all W=1, B=0, in_data all ones -> K=3, acc=10 exactly (tail lanes zero), done at OUT_DIM*5+1.
REQ-039 All W=2047, B=2047, in_data all ones, ACC_W=16 -> acc saturates at 32767, no sign flip, out=1 in det mode.
REQ-040 w_we during busy -> w_err pulse, memory unchanged (rerun gives identical out_data); start while busy ignored.
REQ-041 det_mode=0 with reference LFSR model from SEED -> out_data matches model bit-exact; reset_n low mid-ACCUM -> busy=0, out_data=0, no done.
